mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, cycles from request acceptance to resp_valid; legal range 1..15.
REQ-002 Parameter DEPTH_LOG2, default 8, log2 of storage depth in 32-bit words.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_byte  input  1  1 = byte access, 0 = word access.
REQ-010 req_wdata  input  32  store data; byte stores use bits 7:0.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator accepts the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  request was rejected as misaligned.

Function
REQ-015 The block SHALL use three states: IDLE, BUSY and RESP.
REQ-016 In IDLE, req_ready SHALL be 1; in BUSY and RESP, req_ready SHALL be 0.
REQ-017 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; addr, write, byte and wdata are captured and the state moves to BUSY.
REQ-018 A latency counter SHALL load LATENCY-1 on acceptance and decrement once per cycle in BUSY.
REQ-019 When the counter is 0, the state SHALL move to RESP, so resp_valid rises exactly LATENCY edges after acceptance.
REQ-020 The access SHALL be performed on the BUSY-to-RESP edge; resp_rdata and resp_err SHALL be registered at that same edge and held stable throughout RESP.
REQ-021 Word index SHALL be addr[DEPTH_LOG2+1:2]; higher address bits are ignored, so addresses wrap modulo the storage size.
REQ-022 A word load SHALL return the stored word.
REQ-023 A byte load SHALL return the lane selected by addr[1:0], zero-extended; lane 0 is bits 7:0 and lane 3 is bits 31:24.
REQ-024 A word store SHALL overwrite the whole word.
REQ-025 A byte store SHALL overwrite only the lane selected by addr[1:0], using wdata[7:0].
REQ-026 A word access with addr[1:0] != 0 SHALL set resp_err=1 and resp_rdata=0, and SHALL leave storage unmodified.
REQ-027 While in RESP, resp_valid SHALL be 1; on an edge where resp_ready=1, the state SHALL return to IDLE and resp_valid SHALL drop to 0.
REQ-028 A new request SHALL NOT be accepted in the same cycle as a response handshake; the earliest acceptance is the cycle after returning to IDLE.
REQ-029 Changes on req_* inputs while in BUSY or RESP SHALL have no effect.

Reset
REQ-030 While reset=1, the block SHALL hold: state IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, counter=0, all storage words 0.
REQ-031 Reset in BUSY SHALL abort the pending access (no storage change); reset in RESP SHALL discard the response.
REQ-032 req_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-033 Package mem_responder_pkg SHALL hold the state enumeration and the lane-select width constant.
REQ-034 Sub-module byte_lane_unit SHALL implement load lane extraction and store lane merge combinationally.
REQ-035 Storage, counter and FSM SHALL live in mem_responder.

Verification
REQ-036 LATENCY=2: word store 0xDEADBEEF to addr 0x10, then word load of 0x10 -> resp_valid 2 edges after each acceptance, load rdata=0xDEADBEEF, err=0.
REQ-037 Byte store 0xAB to addr 0x13 over word 0x11223344 -> a subsequent word load of 0x10 returns 0xAB223344, and a byte load of 0x12 returns 0x00000022.
REQ-038 Word load of addr 0x6 -> err=1, rdata=0; a word store to 0x6 -> err=1 and storage unchanged.
REQ-039 Hold resp_ready=0 for 5 cycles -> resp_valid and rdata stable and req_ready=0; handshake, then req_ready=1 on the next cycle only.
REQ-040 Assert reset one cycle after a store is accepted -> no response; the address reads 0 afterwards.
REQ-041 DEPTH_LOG2=8: store to 0x400 and load 0x000 -> the stored value is returned (wrap-around).

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
package mem_responder_pkg;

  // Width of the byte-lane select taken from addr[1:0].
  localparam int unsigned LaneSelW = 2;

  // Latency counter width; covers LATENCY-1 for LATENCY up to 15.
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane helper: extracts a zero-extended load byte and
// merges a store byte into a word, both selected by the lane index.
module byte_lane_unit
  import mem_responder_pkg::*;
(
  input  logic [31:0]         word,
  input  logic [LaneSelW-1:0] lane,
  input  logic [7:0]          wbyte,
  output logic [31:0]         lane_rdata,
  output logic [31:0]         merged_word
);

  // Lane 0 is bits 7:0, lane 3 is bits 31:24.
  always_comb begin
    lane_rdata  = '0;
    merged_word = word;
    unique case (lane)
      2'd0: begin
        lane_rdata       = {24'h0, word[7:0]};
        merged_word[7:0] = wbyte;
      end
      2'd1: begin
        lane_rdata        = {24'h0, word[15:8]};
        merged_word[15:8] = wbyte;
      end
      2'd2: begin
        lane_rdata         = {24'h0, word[23:16]};
        merged_word[23:16] = wbyte;
      end
      2'd3: begin
        lane_rdata         = {24'h0, word[31:24]};
        merged_word[31:24] = wbyte;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed response latency.
// Accepts one load/store, performs it LATENCY edges later, and holds the
// registered response until the initiator takes it.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned AddrW = DEPTH_LOG2 + 2;

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic accept;
  logic access;

  logic [AddrW-1:0] addr_q;
  logic             write_q;
  logic             byte_q;
  logic [31:0]      wdata_q;

  logic [31:0] mem_q [Depth];

  logic [DEPTH_LOG2-1:0] idx;
  logic [LaneSelW-1:0]   lane;
  logic                  misaligned;
  logic [31:0]           rd_word;
  logic [31:0]           lane_rdata;
  logic [31:0]           merged_word;
  logic                  mem_we;
  logic [31:0]           mem_wdata;

  logic [31:0] rdata_q;
  logic        err_q;

  // Address bits above the storage range are intentionally ignored (wrap).
  logic unused_addr;
  if (AddrW < 32) begin : g_unused_addr
    assign unused_addr = ^req_addr[31:AddrW];
  end else begin : g_no_unused_addr
    assign unused_addr = 1'b0;
  end

  assign idx        = addr_q[AddrW-1:2];
  assign lane       = addr_q[1:0];
  assign misaligned = !byte_q && (lane != '0);
  assign rd_word    = mem_q[idx];

  // Held low during reset so the initiator cannot hand off into a reset.
  assign req_ready  = (state_q == StIdle) && !reset;
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  byte_lane_unit u_byte_lane_unit (
    .word        (rd_word),
    .lane        (lane),
    .wbyte       (wdata_q[7:0]),
    .lane_rdata  (lane_rdata),
    .merged_word (merged_word)
  );

  // Next-state and latency counter control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = StBusy;
          cnt_d   = CntW'(LATENCY - 1);
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and latency counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request so later input changes have no effect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr[AddrW-1:0];
      write_q <= req_write;
      byte_q  <= req_byte;
      wdata_q <= req_wdata;
    end
  end

  // Misaligned word stores are dropped; byte stores merge into the old word.
  always_comb begin
    mem_we    = access && write_q && !misaligned;
    mem_wdata = byte_q ? merged_word : wdata_q;
  end

  // Storage array, cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx] <= mem_wdata;
    end
  end

  // Response registered on the BUSY-to-RESP edge and held through RESP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (access) begin
      err_q <= misaligned;
      if (misaligned || write_q) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= byte_q ? lane_rdata : rd_word;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the driver queues expected responses,
// an independent monitor checks each response as resp_valid rises.
module tb_mem_responder;

  localparam int unsigned Lat = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          edge_no;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  mem_responder #(
    .LATENCY    (Lat),
    .DEPTH_LOG2 (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_byte   (req_byte),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Monitor: one comparison set per rising edge of resp_valid.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (resp_valid === 1'b1 && !prev) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_resp: got resp_valid=1 want no response");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_rdata"}, resp_rdata, e.rdata);
          check({e.name, "_err"}, {31'h0, resp_err}, {31'h0, e.err});
          check({e.name, "_latency"}, 32'(cyc - e.edge_no), Lat);
        end
      end
      prev = (resp_valid === 1'b1);
    end
  end

  // Issue one request; junk is left on req_* (valid still high) for one
  // busy cycle afterwards, which the responder must ignore.
  task automatic issue(input string name, input logic [31:0] addr, input logic wr,
                       input logic by, input logic [31:0] wd, input logic [31:0] er,
                       input logic ee, input bit push);
    int n;
    n = 0;
    @(negedge clock);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (req_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_ready_timeout: got req_ready=%b want 1", name, req_ready);
      return;
    end
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_byte  = by;
    req_wdata = wd;
    if (push) begin
      exp_t e;
      e.rdata   = er;
      e.err     = ee;
      e.edge_no = cyc + 1;
      e.name    = name;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    req_addr  = $urandom;
    req_write = 1'b1;
    req_byte  = 1'b0;
    req_wdata = $urandom;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
    @(negedge clock);
  endtask

  initial begin
    int n;
    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    reset = 1'b0;
    #1;
    check("rst_release_ready", {31'h0, req_ready}, 32'h1);

    // Word store/load.
    issue("st_dead", 32'h10, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    issue("ld_dead", 32'h10, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

    // Byte store merge and byte loads.
    issue("st_1122", 32'h10, 1'b1, 1'b0, 32'h11223344, 32'h0, 1'b0, 1'b1);
    issue("stb_ab", 32'h13, 1'b1, 1'b1, 32'hFFFFFFAB, 32'h0, 1'b0, 1'b1);
    issue("ld_merged", 32'h10, 1'b0, 1'b0, 32'h0, 32'hAB223344, 1'b0, 1'b1);
    issue("ldb_lane2", 32'h12, 1'b0, 1'b1, 32'h0, 32'h00000022, 1'b0, 1'b1);
    issue("ldb_lane3", 32'h13, 1'b0, 1'b1, 32'h0, 32'h000000AB, 1'b0, 1'b1);
    issue("ldb_lane0", 32'h10, 1'b0, 1'b1, 32'h0, 32'h00000044, 1'b0, 1'b1);

    // Misaligned word accesses.
    issue("ld_mis", 32'h6, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    issue("st_5566", 32'h4, 1'b1, 1'b0, 32'h55667788, 32'h0, 1'b0, 1'b1);
    issue("st_mis", 32'h6, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
    issue("ld_unchg", 32'h4, 1'b0, 1'b0, 32'h0, 32'h55667788, 1'b0, 1'b1);

    // Address wrap at 256 words.
    issue("st_wrap", 32'h400, 1'b1, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
    issue("ld_wrap", 32'h0, 1'b0, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    drain();

    // Back-pressure: response held for 5 cycles.
    resp_ready = 1'b0;
    issue("ld_hold", 32'h10, 1'b0, 1'b0, 32'h0, 32'hAB223344, 1'b0, 1'b1);
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'h0, resp_valid}, 32'h1);
      check("hold_rdata", resp_rdata, 32'hAB223344);
      check("hold_req_ready", {31'h0, req_ready}, 32'h0);
      @(negedge clock);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    check("post_hs_valid", {31'h0, resp_valid}, 32'h0);
    check("post_hs_ready", {31'h0, req_ready}, 32'h1);
    drain();

    // Reset while a store is pending.
    issue("st_abort", 32'h20, 1'b1, 1'b0, 32'h12345678, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("abort_valid", {31'h0, resp_valid}, 32'h0);
    check("abort_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clock);
    check("abort_valid2", {31'h0, resp_valid}, 32'h0);
    check("abort_rdata", resp_rdata, 32'h0);
    reset = 1'b0;
    #1;
    check("abort_release_ready", {31'h0, req_ready}, 32'h1);
    issue("ld_aborted", 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    issue("ld_cleared", 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
